// File: rtl/segrun_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | segrun_pkg                                                           |
// | Shared types and constants for the SegmentRunner obstacle sequencer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package segrun_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    // Taps for x^8+x^6+x^5+x^4+1 with a left-shifting register
    localparam logic [7:0] c_lfsr_taps = 8'hB8;

    localparam int unsigned c_tick_div_dflt = 5_000_000;
    localparam int unsigned c_min_div_dflt  = 1_000_000;
    localparam int unsigned c_step_div_dflt = 500_000;

    function automatic int unsigned width_of(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_lfsr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | obstacle_lfsr_gen                                                    |
// | LFSR obstacle stream with post-start grace and minimum-gap shaping.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module obstacle_lfsr_gen
    import segrun_pkg::*;
#(
    parameter int unsigned MIN_GAP   = 2,
    parameter int unsigned GRACE     = 6,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Adv,
    input  logic Restart,
    output logic Bit
);

    localparam int unsigned GAP_W   = width_of(MIN_GAP);
    localparam int unsigned GRACE_W = width_of(GRACE);
    localparam logic [GAP_W-1:0]   c_gap_max  = GAP_W'(MIN_GAP);
    localparam logic [GRACE_W-1:0] c_grace_in = GRACE_W'(GRACE);

    logic [7:0]         lfsr_q,  lfsr_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic [GRACE_W-1:0] grace_q, grace_d;
    logic               bit_q,   bit_d;
    logic [7:0]         w_lfsr_next;

    always_comb begin
        w_lfsr_next = {lfsr_q[6:0], ^(lfsr_q & c_lfsr_taps)};
        lfsr_d      = lfsr_q;
        gap_d       = gap_q;
        grace_d     = grace_q;
        bit_d       = bit_q;
        if (Restart) begin
            // Lane is cleared on restart, so it already counts as a full gap
            grace_d = c_grace_in;
            gap_d   = c_gap_max;
            bit_d   = 1'b0;
        end else if (Adv) begin
            lfsr_d = w_lfsr_next;
            if (grace_q != '0) begin
                grace_d = grace_q - GRACE_W'(1);
                bit_d   = 1'b0;
            end else if (gap_q < c_gap_max) begin
                bit_d = 1'b0;
            end else begin
                bit_d = w_lfsr_next[0] & w_lfsr_next[1];
            end
            if (bit_d) begin
                gap_d = '0;
            end else if (gap_q < c_gap_max) begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lfsr_q  <= LFSR_SEED;
            gap_q   <= c_gap_max;
            grace_q <= c_grace_in;
            bit_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
            grace_q <= grace_d;
            bit_q   <= bit_d;
        end
    end

    assign Bit = bit_q;

endmodule
`default_nettype wire

// File: rtl/obstacle_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | obstacle_scroll_ctrl                                                 |
// | Shift-strobe pacing, level/score tracking and hit detection.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module obstacle_scroll_ctrl
    import segrun_pkg::*;
#(
    parameter int unsigned TICK_DIV         = c_tick_div_dflt,
    parameter int unsigned MIN_DIV          = c_min_div_dflt,
    parameter int unsigned STEP_DIV         = c_step_div_dflt,
    parameter int unsigned SHIFTS_PER_LEVEL = 16,
    parameter int unsigned MIN_GAP          = 2,
    parameter int unsigned GRACE            = 6,
    parameter logic [7:0]  LFSR_SEED        = 8'hA5,
    parameter int unsigned SCORE_W          = 10
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               PlayerUp,
    input  logic [5:0]         LaneIn,
    output logic               Shift,
    output logic               BitIn,
    output logic               RegRstN,
    output logic               Running,
    output logic               GameOver,
    output logic [SCORE_W-1:0] Score,
    output logic [2:0]         Level
);

    localparam int unsigned SPL_W = width_of(SHIFTS_PER_LEVEL - 1);
    localparam logic [31:0]        c_tick_div  = 32'(TICK_DIV);
    localparam logic [31:0]        c_min_div   = 32'(MIN_DIV);
    localparam logic [31:0]        c_step_div  = 32'(STEP_DIV);
    localparam logic [SPL_W-1:0]   c_lvl_last  = SPL_W'(SHIFTS_PER_LEVEL - 1);
    localparam logic [SCORE_W-1:0] c_score_max = '1;

    state_t             state_q,      state_d;
    logic               start_prev_q, start_prev_d;
    logic [31:0]        cnt_q,        cnt_d;
    logic [31:0]        period_q,     period_d;
    logic [SPL_W-1:0]   lvl_cnt_q,    lvl_cnt_d;
    logic [2:0]         level_q,      level_d;
    logic [SCORE_W-1:0] score_q,      score_d;
    logic               shift_q,      shift_d;
    logic               regrstn_q,    regrstn_d;
    logic               running_q,    running_d;
    logic               gameover_q,   gameover_d;
    logic [1:0]         chk_q,        chk_d;

    logic w_start_rise, w_enter, w_adv, w_hit, w_clear;
    logic w_unused_lane;

    assign w_unused_lane = ^LaneIn[4:0];

    always_comb begin
        state_d      = state_q;
        start_prev_d = Start;
        cnt_d        = cnt_q;
        period_d     = period_q;
        lvl_cnt_d    = lvl_cnt_q;
        level_d      = level_q;
        score_d      = score_q;
        shift_d      = 1'b0;
        regrstn_d    = 1'b1;
        running_d    = running_q;
        gameover_d   = gameover_q;
        // Hit check fires two cycles after Shift so the lane has settled
        chk_d        = {chk_q[0], shift_q};
        w_start_rise = Start & ~start_prev_q;
        w_enter      = 1'b0;
        w_adv        = 1'b0;
        w_hit        = chk_q[1] & LaneIn[5] & ~PlayerUp;
        w_clear      = chk_q[1] & LaneIn[5] & PlayerUp;

        case (state_q)
            ST_IDLE, ST_HIT: w_enter = w_start_rise;
            ST_RUN: begin
                w_adv = (cnt_q == 32'd1);
                if (cnt_q == 32'd0) begin
                    shift_d = 1'b1;
                    cnt_d   = period_q - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
                if (w_hit) begin
                    state_d    = ST_HIT;
                    shift_d    = 1'b0;
                    running_d  = 1'b0;
                    gameover_d = 1'b1;
                end else begin
                    if (w_clear && (score_q != c_score_max)) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    if (shift_q) begin
                        if (lvl_cnt_q == c_lvl_last) begin
                            lvl_cnt_d = '0;
                            if (level_q != 3'd7) begin
                                level_d = level_q + 3'd1;
                            end
                            // period never drops below MIN_DIV, so this cannot wrap
                            period_d = ((period_q - c_min_div) >= c_step_div)
                                     ? (period_q - c_step_div) : c_min_div;
                        end else begin
                            lvl_cnt_d = lvl_cnt_q + SPL_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_enter) begin
            state_d    = ST_RUN;
            running_d  = 1'b1;
            gameover_d = 1'b0;
            regrstn_d  = 1'b0;
            score_d    = '0;
            level_d    = 3'd0;
            lvl_cnt_d  = '0;
            period_d   = c_tick_div;
            cnt_d      = c_tick_div - 32'd1;
            chk_d      = 2'b00;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            cnt_q        <= 32'd0;
            period_q     <= c_tick_div;
            lvl_cnt_q    <= '0;
            level_q      <= 3'd0;
            score_q      <= '0;
            shift_q      <= 1'b0;
            regrstn_q    <= 1'b1;
            running_q    <= 1'b0;
            gameover_q   <= 1'b0;
            chk_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            lvl_cnt_q    <= lvl_cnt_d;
            level_q      <= level_d;
            score_q      <= score_d;
            shift_q      <= shift_d;
            regrstn_q    <= regrstn_d;
            running_q    <= running_d;
            gameover_q   <= gameover_d;
            chk_q        <= chk_d;
        end
    end

    obstacle_lfsr_gen #(
        .MIN_GAP   (MIN_GAP),
        .GRACE     (GRACE),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr_gen (
        .Clk     (Clk),
        .Rst     (Rst),
        .Adv     (w_adv),
        .Restart (w_enter),
        .Bit     (BitIn)
    );

    assign Shift    = shift_q;
    assign RegRstN  = regrstn_q;
    assign Running  = running_q;
    assign GameOver = gameover_q;
    assign Score    = score_q;
    assign Level    = level_q;

endmodule
`default_nettype wire
